// File: rtl/fir_pkg.sv
// Shared FIR constants and sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } fir_state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: TAPS x DW, synchronous write, combinational read.
// Latency: a write is visible on rd_data the cycle after its clock edge.
// Backpressure: none; the parent gates wr_en so writes only land while idle.
// Ports: clk/rst (sync, active-low clear of every entry), wr_en/wr_addr/wr_data
//        write port, rd_addr/rd_data asynchronous read port.
module fir_coeff_bank #(
  parameter int TAPS = 64,
  parameter int DW   = 16,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [TAPS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: stores one sample per output in a circular delay line and
//   streams TAPS (x[n-k], coeff[k]) pairs to the MAC, one per clock.
// Latency: mac_clr one cycle after accept, pair 0 two cycles after accept.
// Backpressure: in_ready only in IDLE; the next sample waits for mac_tick.
// Ports: clk, rst (sync active-low); in_sample/in_valid/in_ready sample input;
//        coeff_wr_* coefficient write port (IDLE only); mac_clr/mac_x/mac_coeff/
//        mac_vld MAC drive; mac_tick MAC completion; busy = not IDLE.
module fir_tap_sequencer #(
  parameter int TAPS = fir_pkg::TAPS,
  parameter int DW   = fir_pkg::DW,
  parameter int AW   = fir_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_sample,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          coeff_wr_en,
  input  logic [AW-1:0] coeff_wr_addr,
  input  logic [DW-1:0] coeff_wr_data,
  output logic          mac_clr,
  output logic [DW-1:0] mac_x,
  output logic [DW-1:0] mac_coeff,
  output logic          mac_vld,
  input  logic          mac_tick,
  output logic          busy
);

  import fir_pkg::*;

  fir_state_t    state, state_nxt;
  logic [AW-1:0] wr_ptr, head, k;
  logic [DW-1:0] dl [TAPS];
  logic          accept;
  logic          last_pair;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] dl_idx;
  logic [DW-1:0] coeff_rd;

  // Coefficient writes are dropped outside IDLE.
  fir_coeff_bank #(.TAPS(TAPS), .DW(DW), .AW(AW)) u_coeff_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (coeff_wr_en && (state == ST_IDLE)),
    .wr_addr (coeff_wr_addr),
    .wr_data (coeff_wr_data),
    .rd_addr (rd_addr),
    .rd_data (coeff_rd)
  );

  // k is the index of the pair currently on the MAC outputs; the read port
  // looks one pair ahead so that the outputs can be registered.
  assign last_pair = (k == AW'(TAPS - 1));
  assign rd_addr   = (state == ST_CLEAR) ? '0 : AW'(k + AW'(1));
  assign dl_idx    = AW'(head - rd_addr);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR:  state_nxt = ST_STREAM;
      ST_STREAM: if (last_pair) state_nxt = ST_WAIT;
      ST_WAIT:   if (mac_tick) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      head      <= '0;
      k         <= '0;
      mac_clr   <= 1'b0;
      mac_vld   <= 1'b0;
      mac_x     <= '0;
      mac_coeff <= '0;
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
    end else begin
      mac_clr <= accept;
      if (accept) begin
        dl[wr_ptr] <= in_sample;
        head       <= wr_ptr;
      end
      case (state)
        ST_CLEAR: begin
          k         <= '0;
          mac_vld   <= 1'b1;
          mac_x     <= dl[dl_idx];
          mac_coeff <= coeff_rd;
        end
        ST_STREAM: begin
          if (last_pair) begin
            mac_vld   <= 1'b0;
            mac_x     <= '0;
            mac_coeff <= '0;
          end else begin
            k         <= AW'(k + AW'(1));
            mac_vld   <= 1'b1;
            mac_x     <= dl[dl_idx];
            mac_coeff <= coeff_rd;
          end
        end
        ST_WAIT: if (mac_tick) wr_ptr <= AW'(head + AW'(1));
        default: ;
      endcase
    end
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer against a sample-history model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_tap_sequencer;

  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          in_ready;
  logic          coeff_wr_en;
  logic [AW-1:0] coeff_wr_addr;
  logic [DW-1:0] coeff_wr_data;
  logic          mac_clr;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_coeff;
  logic          mac_vld;
  logic          mac_tick;
  logic          busy;

  int n_assert;
  int n_fail;

  // Model: the most recent TAPS accepted samples, newest first, plus the
  // coefficient values as last written in IDLE.
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_coeff [TAPS];

  fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_sample     (in_sample),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .mac_clr       (mac_clr),
    .mac_x         (mac_x),
    .mac_coeff     (mac_coeff),
    .mac_vld       (mac_vld),
    .mac_tick      (mac_tick),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_x(input int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".mac_clr"}, 32'(mac_clr), 32'd0);
    chk({tag, ".mac_vld"}, 32'(mac_vld), 32'd0);
    chk({tag, ".mac_x"}, 32'(mac_x), 32'd0);
    chk({tag, ".mac_coeff"}, 32'(mac_coeff), 32'd0);
  endtask

  task automatic load_coeff(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = AW'(addr);
    coeff_wr_data = data;
    m_coeff[addr] = data;
    @(negedge clk);
    coeff_wr_en = 1'b0;
  endtask

  // One full transaction. Options: coefficient write alongside in_valid,
  // in_valid held high while busy, dropped coefficient write mid-stream,
  // stray mac_tick mid-stream, reset at pair abort_k (-1: none).
  task automatic send_sample(input logic [DW-1:0] s, input bit cw_with_valid,
                             input logic [DW-1:0] cw_val, input bit hold_valid,
                             input bit cw_mid, input bit tick_mid, input int abort_k);
    int w;
    @(negedge clk);
    chk("accept.in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_sample = s;
    if (cw_with_valid) begin
      coeff_wr_en   = 1'b1;
      coeff_wr_addr = '0;
      coeff_wr_data = cw_val;
      m_coeff[0]    = cw_val;
    end
    hist.push_front(s);
    if (hist.size() > TAPS) void'(hist.pop_back());
    @(negedge clk);
    chk("clear.mac_clr", 32'(mac_clr), 32'd1);
    chk("clear.mac_vld", 32'(mac_vld), 32'd0);
    chk("clear.in_ready", 32'(in_ready), 32'd0);
    chk("clear.busy", 32'(busy), 32'd1);
    coeff_wr_en = 1'b0;
    if (!hold_valid) in_valid = 1'b0;
    in_sample = DW'($urandom);
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      chk("stream.mac_vld", 32'(mac_vld), 32'd1);
      chk("stream.mac_clr", 32'(mac_clr), 32'd0);
      chk("stream.mac_x", 32'(mac_x), 32'(exp_x(k)));
      chk("stream.mac_coeff", 32'(mac_coeff), 32'(m_coeff[k]));
      coeff_wr_en = 1'b0;
      mac_tick    = 1'b0;
      if (cw_mid && k == 5) begin
        coeff_wr_en   = 1'b1;
        coeff_wr_addr = '0;
        coeff_wr_data = 16'h7FFF;
      end
      if (tick_mid && k == 10) mac_tick = 1'b1;
      if (k == abort_k) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        chk_idle("abort");
        hist.delete();
        for (int i = 0; i < TAPS; i++) m_coeff[i] = '0;
        return;
      end
    end
    @(negedge clk);
    chk("wait.mac_vld", 32'(mac_vld), 32'd0);
    chk("wait.mac_x", 32'(mac_x), 32'd0);
    chk("wait.mac_coeff", 32'(mac_coeff), 32'd0);
    chk("wait.busy", 32'(busy), 32'd1);
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk("wait.in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    mac_tick = 1'b1;
    @(negedge clk);
    mac_tick = 1'b0;
    chk("tick.in_ready", 32'(in_ready), 32'd1);
    chk("tick.busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    in_sample     = '0;
    in_valid      = 1'b0;
    coeff_wr_en   = 1'b0;
    coeff_wr_addr = '0;
    coeff_wr_data = '0;
    mac_tick      = 1'b0;
    for (int i = 0; i < TAPS; i++) m_coeff[i] = '0;

    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle.mac_vld", 32'(mac_vld), 32'd0);
      chk("idle.in_ready", 32'(in_ready), 32'd1);
    end

    // coeff[k] = k+1, then sample 1, then sample 2 with in_valid held.
    for (int i = 0; i < TAPS; i++) load_coeff(i, DW'(i + 1));
    send_sample(16'd1, 1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
    send_sample(16'd2, 1'b0, '0, 1'b1, 1'b0, 1'b0, -1);

    // Samples 3..65: the last one wraps the delay line.
    for (int v = 3; v <= 65; v++)
      send_sample(DW'(v), 1'b0, '0, 1'b0, 1'b0, (v == 40), -1);
    chk("wrap.hist_oldest", 32'(exp_x(TAPS - 1)), 32'd2);

    // Dropped mid-stream write, then the same write together with in_valid.
    send_sample(DW'($urandom), 1'b0, '0, 1'b0, 1'b1, 1'b0, -1);
    send_sample(DW'($urandom), 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, -1);

    // Random coefficients and samples.
    for (int i = 0; i < TAPS; i++) load_coeff(i, DW'($urandom));
    for (int n = 0; n < 4; n++)
      send_sample(DW'($urandom), 1'b0, '0, ($urandom_range(0, 1) == 1), 1'b0, 1'b0, -1);

    // Reset at pair 30, then a fresh sample sees an empty delay line and zero coefficients.
    send_sample(DW'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0, 30);
    send_sample(16'h1234, 1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 8; i++) load_coeff($urandom_range(0, TAPS - 1), DW'($urandom));
    send_sample(DW'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
